sram_rect_reader: RTL and testbench

Read-side master for the single-port, read-latency-1 image SRAM blocks (background and sprite stores). On a start pulse it walks a rectangular window of a row-major image and streams one pixel per cycle on a valid/ready interface to the compositor. A 2-entry skid FIFO absorbs the SRAM's registered read latency, so backpressure never drops or duplicates a pixel.

---
 rtl/pv_pkg.sv | 22 ++
 rtl/sram_rd_skid.sv | 75 +++++++
 rtl/sram_rect_reader.sv | 208 ++++++++++++++++++++
 tb/tb_sram_rect_reader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pv_pkg.sv
// Shared definitions for the pixel-video read path: reader state encoding,
// pixel tag bundle and the screen geometry used as the default image stride.
package pv_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  // Rectangle reader control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

  // Framing tags that travel alongside each pixel read.
  typedef struct packed {
    logic eof;
    logic eol;
  } pix_tag_t;

endpackage

// File: rtl/sram_rd_skid.sv
// Two-entry synchronous FIFO that absorbs the one-cycle SRAM read latency.
// Push and pop may coincide in the same cycle, including when full; the
// occupancy is then unchanged. A push onto a full FIFO without a pop is dropped.
module sram_rd_skid #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  // Qualify the requests and compute next pointers, occupancy and storage.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  // NOTE: storage is deliberately not reset; an entry is only observed once
  // count_q says it was written, and the top masks the head while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == 2'd2);
  assign empty    = (count_q == 2'd0);
  assign count    = count_q;

endmodule

// File: rtl/sram_rect_reader.sv
// Read-side master for the single-port, read-latency-1 image SRAMs. Walks a
// rectangular window of a row-major image and streams one pixel per cycle on a
// valid/ready interface. Reads are only issued when the skid FIFO is certain to
// have room for the returning data, so backpressure never loses a pixel.
module sram_rect_reader
  import pv_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 17,
  parameter int IMG_W      = SCREEN_W,
  parameter int W_BITS     = 9,
  parameter int H_BITS     = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [W_BITS-1:0]     rect_w,
  input  logic [H_BITS-1:0]     rect_h,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_data,
  output logic                  pix_valid,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_eol,
  output logic                  pix_eof,
  input  logic                  pix_ready
);

  localparam int FIFO_W = DATA_WIDTH + 2;

  rd_state_e             state_q, state_d;
  logic [W_BITS-1:0]     rect_w_q, rect_w_d;
  logic [H_BITS-1:0]     rect_h_q, rect_h_d;
  logic [W_BITS-1:0]     x_q, x_d;
  logic [H_BITS-1:0]     y_q, y_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
  logic                  inflight_q, inflight_d;
  pix_tag_t              tag_q, tag_d;

  logic                  start_ok;
  logic                  zero_size;
  logic                  last_col;
  logic                  last_row;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  pop;
  logic                  can_issue;

  logic [FIFO_W-1:0]     fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [1:0]            fifo_count;

  // Walk decode: start qualification, rectangle edges and the current address.
  always_comb begin
    start_ok  = (state_q == ST_IDLE) && start;
    zero_size = (rect_w == '0) || (rect_h == '0);
    last_col  = (x_q == rect_w_q - W_BITS'(1));
    last_row  = (y_q == rect_h_q - H_BITS'(1));
    rd_addr   = row_base_q + ADDR_WIDTH'(x_q);
  end

  assign pop = pix_valid & pix_ready;

  // A new read may issue only if, after this cycle's pop, the FIFO plus the
  // read already in flight leave at least one free slot for its data.
  assign can_issue = ({1'b0, fifo_count} + {2'b00, inflight_q}) <= (3'd1 + {2'b00, pop});

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = zero_size ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (sram_en && last_col && last_row) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave as soon as the final pixel is handed off, so done follows the
        // eof handshake by exactly one cycle.
        if (!inflight_q && (fifo_empty || (pop && (fifo_count == 2'd1)))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: status flags and the read strobe.
  always_comb begin
    busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done    = (state_q == ST_DONE);
    sram_en = (state_q == ST_RUN) && can_issue;
    sram_we = 1'b0;
  end

  // Rectangle latch and x/y/row_base walk counters.
  always_comb begin
    rect_w_d   = rect_w_q;
    rect_h_d   = rect_h_q;
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;

    if (start_ok) begin
      rect_w_d   = rect_w;
      rect_h_d   = rect_h;
      x_d        = '0;
      y_d        = '0;
      row_base_d = base_addr;
    end else if (sram_en) begin
      if (last_col) begin
        x_d        = '0;
        y_d        = y_q + H_BITS'(1);
        row_base_d = row_base_q + ADDR_WIDTH'(IMG_W);
      end else begin
        x_d = x_q + W_BITS'(1);
      end
    end
  end

  // Read pipeline: inflight flag, framing tags and the held address.
  always_comb begin
    inflight_d  = sram_en;
    tag_d.eol   = sram_en && last_col;
    tag_d.eof   = sram_en && last_col && last_row;
    addr_hold_d = sram_en ? rd_addr : addr_hold_q;
  end

  // Walk and read pipeline registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rect_w_q    <= '0;
      rect_h_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
      row_base_q  <= '0;
      addr_hold_q <= '0;
      inflight_q  <= 1'b0;
      tag_q       <= '0;
    end else begin
      rect_w_q    <= rect_w_d;
      rect_h_q    <= rect_h_d;
      x_q         <= x_d;
      y_q         <= y_d;
      row_base_q  <= row_base_d;
      addr_hold_q <= addr_hold_d;
      inflight_q  <= inflight_d;
      tag_q       <= tag_d;
    end
  end

  // The address follows the walk while reading and holds its last value otherwise.
  assign sram_addr = sram_en ? rd_addr : addr_hold_q;

  sram_rd_skid #(
    .WIDTH(FIFO_W)
  ) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (inflight_q),
    .push_data({tag_q.eof, tag_q.eol, sram_data}),
    .pop      (pop),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Pixel port: FIFO head, masked to zero while nothing is buffered.
  always_comb begin
    pix_valid = !fifo_empty;
    {pix_eof, pix_eol, pix_data} = fifo_empty ? '0 : fifo_head;
  end

  // Data returning while the FIFO is full and nothing leaves would be lost.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(inflight_q && fifo_full && !pop));
    end
  end

endmodule

// File: tb/tb_sram_rect_reader.sv
// Self-checking bench for sram_rect_reader: a table of rectangle jobs plus
// random jobs, each compared against an address/pixel list computed directly
// from the window geometry, and hand sequences for reset and zero-size cases.
module tb_sram_rect_reader;

  localparam int DW     = 8;
  localparam int AW     = 17;
  localparam int IMG_W  = 320;
  localparam int WB     = 9;
  localparam int HB     = 8;
  localparam int ASPACE = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [WB-1:0] rect_w;
  logic [HB-1:0] rect_h;
  logic          busy, done, sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data = '0;
  logic          pix_valid, pix_eol, pix_eof;
  logic [DW-1:0] pix_data;
  logic          pix_ready;

  logic [DW-1:0] mem [0:ASPACE-1];

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int base;
    int w;
    int h;
    int mode;          // 0: ready high, 1: ready 1,0,0,1 repeating, 2: random
    int glitch_k;      // cycle at which a stray start is pulsed, -1 for none
    int exp_n;         // pixels expected
    int exp_done_k;    // cycle of done after start edge, -1 when ready varies
    int exp_last_addr; // address of the final read
  } job_t;

  sram_rect_reader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .IMG_W     (IMG_W),
    .W_BITS    (WB),
    .H_BITS    (HB)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .base_addr(base_addr),
    .rect_w   (rect_w),
    .rect_h   (rect_h),
    .busy     (busy),
    .done     (done),
    .sram_en  (sram_en),
    .sram_we  (sram_we),
    .sram_addr(sram_addr),
    .sram_data(sram_data),
    .pix_valid(pix_valid),
    .pix_data (pix_data),
    .pix_eol  (pix_eol),
    .pix_eof  (pix_eof),
    .pix_ready(pix_ready)
  );

  always #5 clk = ~clk;

  // Read-latency-1 SRAM model.
  always @(posedge clk) begin
    if (sram_en) sram_data <= mem[sram_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic ready_at(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((k % 4) == 0) || ((k % 4) == 3);
    return ($urandom_range(0, 9) < 6);
  endfunction

  task automatic run_job(input job_t j);
    int exp_addr[$];
    int exp_pix[$];
    int k = 0;
    int issued = 0, popped = 0, over = 0, busy_err = 0, stray = 0;
    int extra_reads = 0, extra_pix = 0;
    int first_issue_k = -1, last_hs_k = -1, done_k = -1, last_addr = -1;
    int budget = j.exp_n * 6 + 20;
    bit finished = 0;
    bit nonzero = (j.w != 0) && (j.h != 0);

    // Reference: row-major walk of the window, addresses wrap modulo 2^AW.
    for (int y = 0; y < j.h; y++) begin
      for (int x = 0; x < j.w; x++) begin
        int a;
        a = (j.base + y * IMG_W + x) % ASPACE;
        exp_addr.push_back(a);
        exp_pix.push_back(int'({(x == j.w - 1) && (y == j.h - 1), (x == j.w - 1), mem[a]}));
      end
    end

    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(j.base);
    rect_w    = WB'(j.w);
    rect_h    = HB'(j.h);
    pix_ready = ready_at(j.mode, 0);
    @(negedge clk);
    k = 1;
    while (!finished && (k < budget)) begin
      start     = (k == j.glitch_k);
      base_addr = AW'($urandom);
      rect_w    = WB'($urandom);
      rect_h    = HB'($urandom);
      pix_ready = ready_at(j.mode, k);
      #1;
      if (sram_en) begin
        issued++;
        if (first_issue_k < 0) first_issue_k = k;
        last_addr = int'(sram_addr);
        if (exp_addr.size() != 0) check("read_addr", int'(sram_addr), exp_addr.pop_front());
        else extra_reads++;
      end
      if (pix_valid && (exp_pix.size() == 0)) stray++;
      if (pix_valid && pix_ready) begin
        popped++;
        last_hs_k = k;
        if (exp_pix.size() != 0) check("pixel_eof_eol_data", int'({pix_eof, pix_eol, pix_data}), exp_pix.pop_front());
        else extra_pix++;
      end
      if (issued - popped > 2) over++;
      if (done) begin
        finished = 1;
        done_k   = k;
        if (busy) busy_err++;
      end else if (busy != nonzero) begin
        busy_err++;
      end
      if (!finished) begin
        @(negedge clk);
        k++;
      end
    end

    check("done_seen", int'(finished), 1);
    check("pixels_delivered", popped, j.exp_n);
    check("reads_missing", exp_addr.size(), 0);
    check("reads_extra", extra_reads, 0);
    check("pixels_extra", extra_pix, 0);
    check("valid_without_data", stray, 0);
    check("busy_window", busy_err, 0);
    check("outstanding_over_2", over, 0);
    if (nonzero) begin
      check("first_issue_cycle", first_issue_k, 1);
      check("last_read_addr", last_addr, j.exp_last_addr);
      check("done_after_eof", done_k, last_hs_k + 1);
    end
    if (j.exp_done_k >= 0) check("done_cycle", done_k, j.exp_done_k);

    @(negedge clk);
    start = 1'b0;
    #1;
    check("done_one_cycle", int'(done), 0);
    check("idle_not_busy", int'(busy), 0);
    check("idle_no_valid", int'(pix_valid), 0);
  endtask

  job_t jobs [12];

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    rect_w    = '0;
    rect_h    = '0;
    pix_ready = 1'b0;
    for (int i = 0; i < ASPACE; i++) mem[i] = DW'($urandom);

    //            base    w    h mode glitch  n    done  last
    jobs[0]  = '{0,       4,   2, 0,  -1,     8,   11,   323};
    jobs[1]  = '{0,       4,   2, 1,  -1,     8,   -1,   323};
    jobs[2]  = '{0,       4,   2, 2,  -1,     8,   -1,   323};
    jobs[3]  = '{0,       0,   5, 0,  -1,     0,   1,    0};
    jobs[4]  = '{10,      3,   0, 0,  -1,     0,   1,    0};
    jobs[5]  = '{76799,   2,   1, 0,  -1,     2,   5,    76800};
    jobs[6]  = '{131071,  2,   1, 0,  -1,     2,   5,    0};
    jobs[7]  = '{1000,    1,   1, 0,  -1,     1,   4,    1000};
    jobs[8]  = '{5,       1,   3, 1,  -1,     3,   -1,   645};
    jobs[9]  = '{130000,  7,   5, 2,  -1,     35,  -1,   214};
    jobs[10] = '{0,       4,   2, 1,  3,      8,   -1,   323};
    jobs[11] = '{0,       4,   2, 0,  9,      8,   11,   323};

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_sram_en", int'(sram_en), 0);
    check("rst_sram_we", int'(sram_we), 0);
    check("rst_sram_addr", int'(sram_addr), 0);
    check("rst_pix_valid", int'(pix_valid), 0);
    check("rst_pix_tags", int'({pix_eol, pix_eof}), 0);
    check("rst_pix_data", int'(pix_data), 0);
    reset_n = 1'b1;

    foreach (jobs[i]) run_job(jobs[i]);

    // Random rectangles against the reference walk.
    for (int r = 0; r < 8; r++) begin
      job_t j;
      j.base     = int'($urandom_range(0, ASPACE - 1));
      j.w        = int'($urandom_range(1, 24));
      j.h        = int'($urandom_range(1, 5));
      j.mode     = (r == 0) ? 0 : 2;
      j.glitch_k = -1;
      j.exp_n    = j.w * j.h;
      j.exp_done_k    = (r == 0) ? j.exp_n + 3 : -1;
      j.exp_last_addr = (j.base + (j.h - 1) * IMG_W + j.w - 1) % ASPACE;
      run_job(j);
    end

    // Full-width rows at sustained rate.
    begin
      job_t j;
      j = '{0, 320, 2, 0, -1, 640, 643, 639};
      run_job(j);
    end

    // Reset mid-RUN with one pixel buffered and one read in flight.
    @(negedge clk);
    start     = 1'b1;
    base_addr = '0;
    rect_w    = WB'(8);
    rect_h    = HB'(4);
    pix_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("abort_fifo_holds_pixel", int'(pix_valid), 1);
    check("abort_no_issue_at_two", int'(sram_en), 0);
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    check("abort_status_zero", int'({busy, done, sram_en, sram_we}), 0);
    check("abort_pix_zero", int'({pix_valid, pix_eol, pix_eof, pix_data}), 0);
    check("abort_addr_zero", int'(sram_addr), 0);
    reset_n   = 1'b1;
    pix_ready = 1'b1;
    @(negedge clk);
    #1;
    check("abort_no_done", int'(done), 0);
    check("abort_no_valid", int'(pix_valid), 0);
    run_job(jobs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
